// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-arbiter state encoding.
// Imported by the TX arbiter and by future RX-side blocks.
package uart_pkg;

  localparam int CLK_HZ       = 3125000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = 27;
  localparam int FRAME_CLKS   = 297;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the lowest set request at or above ptr,
// otherwise the lowest set request overall (the wrap case).
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N_REQ-1:0] masked;

  always_comb begin
    masked  = '0;
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      masked[i] = req_i[i] && (i >= int'(ptr_i));
    end
    // Unmasked scan first, masked scan second so a hit at/above ptr wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (masked[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one UART transmitter: sends each requester's message
// byte by byte with even parity and a per-byte completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 512
) (
  input  logic                    clk_3125,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_parity,
  input  logic                    tx_done,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  // Handshake: req[i] with req_data/req_last is held until req_ack[i] pulses;
  // the requester shows its next byte (or drops req) the cycle after the ack.
  // tx_start is a one-cycle pulse with tx_data/tx_parity; tx_done closes it.
  tx_arb_state_t      state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   g_q;
  logic               last_q;
  logic [WD_W-1:0]    wdog_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   req_ack_q;
  logic               tx_start_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic               tx_parity_q;
  logic               timeout_err_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_d;
  logic [DATA_W-1:0]  byte_d;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign ptr_d  = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
  assign byte_d = req_data[int'(g_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk_3125 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      g_q           <= '0;
      last_q        <= 1'b0;
      wdog_q        <= '0;
      grant_q       <= '0;
      req_ack_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_parity_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      req_ack_q     <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            g_q     <= pick_idx;
            grant_q <= N_REQ'(1) << pick_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tx_start_q  <= 1'b1;
          tx_data_q   <= byte_d;
          tx_parity_q <= ^byte_d;
          req_ack_q   <= grant_q;
          last_q      <= req_last[g_q];
          wdog_q      <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // A done coinciding with our own start pulse belongs to no byte.
          if (tx_done && !tx_start_q) begin
            if (!last_q && req[g_q]) begin
              state_q <= ISSUE;
            end else begin
              ptr_q   <= ptr_d;
              grant_q <= '0;
              state_q <= IDLE;
            end
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            ptr_q         <= ptr_d;
            grant_q       <= '0;
            state_q       <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign req_ack     = req_ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign tx_parity   = tx_parity_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares one UART transmitter among `N_REQ` requesters using round-robin arbitration. Each requester may send a multi-byte message.
- Runs in the `clk_3125` domain. It sits between the byte producers (command responders, status reporters) and the transmitter core.
- Sequences the transmitter one byte at a time: issues a start pulse, computes even parity, waits for completion, and guards each byte with a timeout watchdog.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `TIMEOUT`, 512, max cycles from `tx_start` to `tx_done` before abort (one frame ≈ 11×27 = 297 cycles)

Ports:
- `clk_3125`  in  1  3.125 MHz system clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  per-requester byte valid, held until acked
- `req_last`  in  N_REQ  byte presented is last of message
- `req_data`  in  N_REQ*DATA_W  flattened bytes; requester i at `[i*DATA_W +: DATA_W]`
- `req_ack`  out  N_REQ  one-cycle pulse: byte of requester i accepted
- `grant`  out  N_REQ  one-hot owner of the transmitter, 0 when idle
- `tx_start`  out  1  one-cycle pulse to transmitter
- `tx_data`  out  DATA_W  byte to send, valid with `tx_start`, held until next issue
- `tx_parity`  out  1  even parity, `^tx_data`
- `tx_done`  in  1  one-cycle pulse from transmitter at end of stop bit
- `timeout_err`  out  1  one-cycle pulse on watchdog abort
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **States: IDLE, ISSUE, WAIT.**
- **IDLE**
  - If any `req` is high, pick the first set bit scanning upward from `ptr`, wrapping at `N_REQ-1`.
  - Register `g`, set `grant` one-hot, go to ISSUE.
  - `tx_done` seen in IDLE is ignored.
- **ISSUE** (one cycle)
  - Register `tx_start`=1, `tx_data`=`req_data[g]`, `tx_parity`, `req_ack[g]`=1.
  - Latch `last_q`=`req_last[g]`; clear the watchdog; go to WAIT.
- **WAIT**
  - The watchdog increments each cycle.
  - On `tx_done`:
    - if `!last_q && req[g]`, go to ISSUE (same owner, no re-arbitration);
    - else `ptr`←(g+1) mod `N_REQ`, `grant`←0, go to IDLE.
  - If the watchdog reaches `TIMEOUT-1` without `tx_done`:
    - pulse `timeout_err`;
    - abandon the rest of the message;
    - `ptr`←(g+1) mod `N_REQ`, `grant`←0, go to IDLE.
  - `tx_done` and timeout in the same cycle: `tx_done` wins.
- **Burst and fairness rules**
  - A requester that drops `req` mid-message (before `last`) ends its burst at the next `tx_done`, with no error.
  - `ptr` advances only at burst end or abort, never per byte.
  - Requests arriving while the transmitter is owned wait. Their worst-case wait is the sum of the other requesters' messages.
- **Width rules**
  - Watchdog width is `$clog2(TIMEOUT)`.
  - `ptr` and `g` width is `$clog2(N_REQ)`; wrap is explicit, not by overflow.

## Timing
- **Reset values:** `req_ack`=0, `grant`=0, `tx_start`=0, `tx_data`=0, `tx_parity`=0, `timeout_err`=0, `busy`=0, `ptr`=0, state IDLE.
- **Reset mid-operation:** immediate return to reset values. The in-flight byte is not re-acked or re-sent after reset.
- **Start latency:** `req[i]` high before edge k in IDLE gives `grant` after edge k. `tx_start` and `req_ack[i]` are high for the single cycle after edge k+1.
- **Requester handshake:** the requester must present the next byte (or drop `req`) in the cycle after `req_ack`.
- **Next-byte latency:** `tx_done` before edge m gives the next `tx_start` after edge m+1. One idle cycle separates bytes.
- **`tx_done` during the `tx_start` cycle:** ignored, since WAIT has not started.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `uart_pkg`:**
  - `CLK_HZ`=3125000, `BAUD`=115200, `CLKS_PER_BIT`=27, `FRAME_CLKS`=297;
  - state enum `tx_arb_state_t` {IDLE, ISSUE, WAIT}.
- **Sub-module `uart_rr_pick`:** combinational. Takes `req` and `ptr`; outputs `valid` and index. Implemented as a masked priority encoder with wrap. It is reusable by a future RX dispatch block.

## Test plan
- **Single request:** `req[2]`=1, `req_last[2]`=1, data 0xCA -> `grant`=0b0100; `tx_start` pulse 2 cycles after req; `tx_data`=0xCA, `tx_parity`=0; `req_ack[2]` once; IDLE and `ptr`=3 after `tx_done`.
- **Round-robin:** all four requesters hold single-byte messages, `ptr`=0 -> grant order 0,1,2,3,0. Each `tx_start` follows the previous `tx_done` by 2 cycles.
- **Burst:** requester 1 sends 0x11, 0x22, 0x33 (last on 0x33) while requester 0 also requests -> all three bytes sent before `grant` moves to 0; exactly 3 acks to requester 1.
- **Timeout:** no `tx_done` after `tx_start` -> `timeout_err` pulses at cycle 512 of WAIT; the message is dropped; the next requester is granted.
- **Early drop and stray done:** requester drops `req` mid-burst -> burst ends at next `tx_done` with no error. `tx_done` injected in IDLE -> no state change.
- **Async reset:** `reset` asserted in WAIT mid-burst -> all outputs 0 immediately. After release with `req[3]` high, a fresh grant to 3 starts from `ptr`=0.
